// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: code-group stream to GMII RXD/RX_DV/RX_ER.
// Optional good-packet/error counters are built when RX_STATS_EN is defined.
module pcs_receive (
  input  logic        clk,
  input  logic        reset_L,
  input  logic        sync_status,
  input  logic [7:0]  rx_cg,
  input  logic        rx_is_k,
  input  logic        rx_cg_invalid,
  output logic [7:0]  RXD,
  output logic        RX_DV,
  output logic        RX_ER,
  output logic        receiving,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  typedef enum logic [2:0] {
    LINK_FAILED,
    WAIT_FOR_K,
    RX_K,
    IDLE_D,
    RECEIVE,
    TRI_RRI,
    EARLY_END,
    RX_INVALID
  } state_t;

  state_t     state, n_state;
  logic [7:0] s0_cg, s1_cg;
  logic       s0_k, s1_k, s0_inv, s1_inv, s0_v, s1_v;
  logic [7:0] n_rxd;
  logic       n_dv, n_er;

  // Two-stage code-group pipeline; a link failure flushes it
  always_ff @(posedge clk) begin
    if (!reset_L || !sync_status) begin
      s0_cg  <= '0;
      s1_cg  <= '0;
      s0_k   <= 1'b0;
      s1_k   <= 1'b0;
      s0_inv <= 1'b0;
      s1_inv <= 1'b0;
      s0_v   <= 1'b0;
      s1_v   <= 1'b0;
    end else begin
      s0_cg  <= rx_cg;
      s0_k   <= rx_is_k;
      s0_inv <= rx_cg_invalid;
      s0_v   <= 1'b1;
      s1_cg  <= s0_cg;
      s1_k   <= s0_k;
      s1_inv <= s0_inv;
      s1_v   <= s0_v;
    end
  end

  logic k_ok, is_k285, is_s, is_t, is_r, is_v;
  logic d_good, is_idle_d, s0_r;

  assign k_ok      = s1_k && !s1_inv;
  assign is_k285   = k_ok && (s1_cg == 8'hBC);
  assign is_s      = k_ok && (s1_cg == 8'hFB);
  assign is_t      = k_ok && (s1_cg == 8'hFD);
  assign is_r      = k_ok && (s1_cg == 8'hF7);
  assign is_v      = k_ok && (s1_cg == 8'hFE);
  assign d_good    = !s1_k && !s1_inv;
  assign is_idle_d = d_good &&
                     ((s1_cg == 8'hC5) || (s1_cg == 8'h50));
  assign s0_r      = s0_v && s0_k && !s0_inv &&
                     (s0_cg == 8'hF7);

  // Next-state and next-output decode of s1 with s0 look-ahead
  always_comb begin
    n_state = state;
    n_rxd   = 8'h00;
    n_dv    = 1'b0;
    n_er    = 1'b0;
    if (state == LINK_FAILED) begin
      n_state = WAIT_FOR_K;
    end else if (s1_v) begin
      unique case (state)
        WAIT_FOR_K: begin
          if (is_k285) n_state = RX_K;
        end
        RX_K, EARLY_END: begin
          if (is_idle_d) begin
            n_state = IDLE_D;
          end else begin
            n_state = RX_INVALID;
            n_rxd   = 8'h0E;
            n_er    = 1'b1;
          end
        end
        IDLE_D: begin
          if (is_k285) begin
            n_state = RX_K;
          end else if (is_s) begin
            n_state = RECEIVE;
            n_rxd   = 8'h55;
            n_dv    = 1'b1;
          end else begin
            n_state = RX_INVALID;
            n_rxd   = 8'h0E;
            n_er    = 1'b1;
          end
        end
        RECEIVE: begin
          if (d_good) begin
            n_rxd = s1_cg;
            n_dv  = 1'b1;
          end else if (is_t && s0_r) begin
            n_state = TRI_RRI;
          end else if (is_t) begin
            n_rxd = s1_cg;
            n_dv  = 1'b1;
            n_er  = 1'b1;
          end else if (is_k285) begin
            n_state = EARLY_END;
            n_er    = 1'b1;
          end else begin
            n_rxd = 8'hFE;
            n_dv  = 1'b1;
            n_er  = 1'b1;
          end
        end
        TRI_RRI: begin
          if (is_r) begin
            n_state = TRI_RRI;
          end else if (is_k285) begin
            n_state = RX_K;
          end else begin
            n_state = RX_INVALID;
            n_rxd   = 8'h0E;
            n_er    = 1'b1;
          end
        end
        RX_INVALID: begin
          if (is_k285) begin
            n_state = RX_K;
          end else begin
            n_rxd = 8'h0E;
            n_er  = 1'b1;
          end
        end
        default: n_state = LINK_FAILED;
      endcase
    end
  end

  // State and registered GMII outputs; link loss forces idle at once
  always_ff @(posedge clk) begin
    if (!reset_L || !sync_status) begin
      state     <= LINK_FAILED;
      RXD       <= 8'h00;
      RX_DV     <= 1'b0;
      RX_ER     <= 1'b0;
      receiving <= 1'b0;
    end else begin
      state     <= n_state;
      RXD       <= n_rxd;
      RX_DV     <= n_dv;
      RX_ER     <= n_er;
      receiving <= (n_state == RECEIVE) ||
                   (n_state == EARLY_END);
    end
  end

`ifdef RX_STATS_EN
  logic err_seen;

  // Saturating counters; err_seen marks a packet that showed RX_ER
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      pkt_count <= '0;
      err_count <= '0;
      err_seen  <= 1'b0;
    end else if (!sync_status) begin
      err_seen <= 1'b0;
    end else begin
      if (n_er && (err_count != 16'hFFFF))
        err_count <= err_count + 16'd1;
      if (state == IDLE_D && n_state == RECEIVE)
        err_seen <= 1'b0;
      else if (n_er)
        err_seen <= 1'b1;
      if (state == RECEIVE && n_state == TRI_RRI &&
          !err_seen && (pkt_count != 16'hFFFF))
        pkt_count <= pkt_count + 16'd1;
    end
  end
`else
  assign pkt_count = 16'h0000;
  assign err_count = 16'h0000;
`endif

endmodule
